// File: rtl/jtq_pkg.sv
// Shared types for the jump token queue: FIFO entry header, FSM states, field widths.
// The entry stored in the FIFO is {jtq_hdr_t, data}; the payload width is set per instance.
package jtq_pkg;

    localparam int PE_NUM_W  = 3;
    localparam int JMP_DST_W = 17;

    typedef enum logic {
        RUN      = 1'b0,
        WAIT_ACK = 1'b1
    } jtq_state_e;

    typedef struct packed {
        logic                 gate;
        logic [PE_NUM_W-1:0]  pe_num;
        logic                 lr;
        logic                 memw;
        logic [JMP_DST_W-1:0] dst;
    } jtq_hdr_t;

    localparam int HDR_W = $bits(jtq_hdr_t);

endpackage

// File: rtl/jmp_token_queue_if.sv
// Request, token and gate signals between the jump unit, the token queue and the PE network.
// The queue connects through the slave modport; the upstream/network side uses master.
interface jmp_token_queue_if #(
    parameter int DATA_W = 32
);
    import jtq_pkg::*;

    logic                 req_valid_i_jtq;
    logic                 pe_out_i_jtq;
    logic [PE_NUM_W-1:0]  pe_num_i_jtq;
    logic                 pe_lr_i_jtq;
    logic                 f_mem_w_i_jtq;
    logic                 jmp_dst_valid_i_jtq;
    logic [JMP_DST_W-1:0] jmp_dst_i_jtq;
    logic                 gate_i_jtq;
    logic [DATA_W-1:0]    opr0_i_jtq;
    logic                 stall_o_jtq;
    logic                 tok_valid_o_jtq;
    logic                 tok_ready_i_jtq;
    logic [PE_NUM_W-1:0]  tok_pe_num_o_jtq;
    logic                 tok_lr_o_jtq;
    logic                 tok_memw_o_jtq;
    logic [JMP_DST_W-1:0] tok_dst_o_jtq;
    logic [DATA_W-1:0]    tok_data_o_jtq;
    logic                 redirect_valid_o_jtq;
    logic [JMP_DST_W-1:0] redirect_dst_o_jtq;
    logic                 gate_ack_i_jtq;
    logic                 gate_busy_o_jtq;

    modport master (
        output req_valid_i_jtq, pe_out_i_jtq, pe_num_i_jtq, pe_lr_i_jtq, f_mem_w_i_jtq,
               jmp_dst_valid_i_jtq, jmp_dst_i_jtq, gate_i_jtq, opr0_i_jtq,
               tok_ready_i_jtq, gate_ack_i_jtq,
        input  stall_o_jtq, tok_valid_o_jtq, tok_pe_num_o_jtq, tok_lr_o_jtq, tok_memw_o_jtq,
               tok_dst_o_jtq, tok_data_o_jtq, redirect_valid_o_jtq, redirect_dst_o_jtq,
               gate_busy_o_jtq
    );

    modport slave (
        input  req_valid_i_jtq, pe_out_i_jtq, pe_num_i_jtq, pe_lr_i_jtq, f_mem_w_i_jtq,
               jmp_dst_valid_i_jtq, jmp_dst_i_jtq, gate_i_jtq, opr0_i_jtq,
               tok_ready_i_jtq, gate_ack_i_jtq,
        output stall_o_jtq, tok_valid_o_jtq, tok_pe_num_o_jtq, tok_lr_o_jtq, tok_memw_o_jtq,
               tok_dst_o_jtq, tok_data_o_jtq, redirect_valid_o_jtq, redirect_dst_o_jtq,
               gate_busy_o_jtq
    );

endinterface

// File: rtl/jtq_fifo.sv
// First-word-fall-through FIFO for queued tokens and gate markers.
// The head entry is readable combinationally; pointers wrap modulo DEPTH (power of two).
module jtq_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/jmp_token_queue.sv
// Jump-unit output stage: queues PE tokens, issues local fetch redirects, serialises gates.
// Define JTQ_BYPASS_EN to present a token combinationally when the queue is empty and idle.
module jmp_token_queue
    import jtq_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input logic               clk_i_jtq,
    input logic               rst_i_jtq,
    jmp_token_queue_if.slave  jtq
);
    localparam int ENT_W = HDR_W + DATA_W;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int TOK_W = PE_NUM_W + 2 + JMP_DST_W + DATA_W;

    jtq_state_e           state_reg, state_next;
    logic                 acc, stall, full, push, pop, empty;
    logic                 head_tok, byp, tok_valid, redir_hit;
    logic [CW-1:0]        count;
    jtq_hdr_t             req_hdr, head_hdr;
    logic [DATA_W-1:0]    head_data;
    logic [ENT_W-1:0]     head_ent;
    logic [TOK_W-1:0]     tok_fields, last_fields_reg;
    logic                 redirect_valid_reg;
    logic [JMP_DST_W-1:0] redirect_dst_reg;

    // Stall looks only at registered state so upstream never sees a combinational loop.
    assign full  = (count == CW'(DEPTH));
    assign stall = full | (state_reg == WAIT_ACK);
    assign acc   = jtq.req_valid_i_jtq & ~stall;

    assign req_hdr = '{gate:   jtq.gate_i_jtq,
                       pe_num: jtq.pe_num_i_jtq,
                       lr:     jtq.pe_lr_i_jtq,
                       memw:   jtq.f_mem_w_i_jtq,
                       dst:    jtq.jmp_dst_i_jtq};

    assign {head_hdr, head_data} = head_ent;
    assign head_tok = (state_reg == RUN) & ~empty & ~head_hdr.gate;

`ifdef JTQ_BYPASS_EN
    assign byp = acc & ~rst_i_jtq & empty & (state_reg == RUN)
               & jtq.pe_out_i_jtq & ~jtq.gate_i_jtq;
`else
    assign byp = 1'b0;
`endif

    assign tok_valid = head_tok | byp;
    // A bypassed token taken by the network in the same cycle never enters the queue.
    assign push      = acc & (jtq.pe_out_i_jtq | jtq.gate_i_jtq) & ~(byp & jtq.tok_ready_i_jtq);
    assign redir_hit = acc & jtq.jmp_dst_valid_i_jtq & ~jtq.pe_out_i_jtq & ~jtq.gate_i_jtq;

    jtq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk   (clk_i_jtq),
        .rst   (rst_i_jtq),
        .push  (push),
        .pop   (pop),
        .wdata ({req_hdr, jtq.opr0_i_jtq}),
        .rdata (head_ent),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        case (state_reg)
            RUN: begin
                if (!empty) begin
                    if (head_hdr.gate) begin
                        pop        = 1'b1;
                        state_next = WAIT_ACK;
                    end else begin
                        pop = jtq.tok_ready_i_jtq;
                    end
                end
            end
            WAIT_ACK: begin
                if (jtq.gate_ack_i_jtq) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // Token fields show the offered token, otherwise the last one offered.
    always_comb begin
        tok_fields = last_fields_reg;
        if (byp) begin
            tok_fields = {req_hdr.pe_num, req_hdr.lr, req_hdr.memw, req_hdr.dst, jtq.opr0_i_jtq};
        end else if (head_tok) begin
            tok_fields = {head_hdr.pe_num, head_hdr.lr, head_hdr.memw, head_hdr.dst, head_data};
        end
    end

    always_ff @(posedge clk_i_jtq or posedge rst_i_jtq) begin
        if (rst_i_jtq) begin
            state_reg          <= RUN;
            last_fields_reg    <= '0;
            redirect_valid_reg <= 1'b0;
            redirect_dst_reg   <= '0;
        end else begin
            state_reg          <= state_next;
            redirect_valid_reg <= redir_hit;
            if (tok_valid) begin
                last_fields_reg <= tok_fields;
            end
            if (redir_hit) begin
                redirect_dst_reg <= jtq.jmp_dst_i_jtq;
            end
        end
    end

    assign jtq.stall_o_jtq          = stall;
    assign jtq.tok_valid_o_jtq      = tok_valid;
    assign {jtq.tok_pe_num_o_jtq, jtq.tok_lr_o_jtq, jtq.tok_memw_o_jtq,
            jtq.tok_dst_o_jtq, jtq.tok_data_o_jtq} = tok_fields;
    assign jtq.redirect_valid_o_jtq = redirect_valid_reg;
    assign jtq.redirect_dst_o_jtq   = redirect_dst_reg;
    assign jtq.gate_busy_o_jtq      = (state_reg == WAIT_ACK);

endmodule

// File: tb/tb_jmp_token_queue.sv
// Directed bench for jmp_token_queue: redirect, single token, full queue, gate, reset.
// Inputs change 1ns after the rising edge; outputs are checked on the falling edge.
module tb_jmp_token_queue;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    jmp_token_queue_if #(.DATA_W(32)) bus ();

    jmp_token_queue #(
        .DEPTH  (4),
        .DATA_W (32)
    ) dut (
        .clk_i_jtq (clk),
        .rst_i_jtq (rst),
        .jtq       (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("[%0t] FAIL %s: got=%0h exp=%0h", $time, tag, got, exp);
        end else begin
            $display("[%0t] ok   %s: got=%0h", $time, tag, got);
        end
    endtask

    task automatic set_req(input logic v, input logic po, input logic [2:0] pn, input logic lr,
                           input logic mw, input logic dv, input logic [16:0] dst,
                           input logic g, input logic [31:0] d);
        bus.req_valid_i_jtq     = v;
        bus.pe_out_i_jtq        = po;
        bus.pe_num_i_jtq        = pn;
        bus.pe_lr_i_jtq         = lr;
        bus.f_mem_w_i_jtq       = mw;
        bus.jmp_dst_valid_i_jtq = dv;
        bus.jmp_dst_i_jtq       = dst;
        bus.gate_i_jtq          = g;
        bus.opr0_i_jtq          = d;
    endtask

    task automatic clr_req();
        set_req(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 17'd0, 1'b0, 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"},     64'(bus.stall_o_jtq), 64'd0);
        chk({tag, "_tok_valid"}, 64'(bus.tok_valid_o_jtq), 64'd0);
        chk({tag, "_tok_data"},  64'(bus.tok_data_o_jtq), 64'd0);
        chk({tag, "_tok_pe"},    64'(bus.tok_pe_num_o_jtq), 64'd0);
        chk({tag, "_redir_v"},   64'(bus.redirect_valid_o_jtq), 64'd0);
        chk({tag, "_redir_dst"}, 64'(bus.redirect_dst_o_jtq), 64'd0);
        chk({tag, "_busy"},      64'(bus.gate_busy_o_jtq), 64'd0);
    endtask

    initial begin
        clr_req();
        bus.tok_ready_i_jtq = 1'b0;
        bus.gate_ack_i_jtq  = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        tick();
        rst = 1'b0;

        // local redirect
        tick();
        set_req(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 17'h1ABCD, 1'b0, 32'd0);
        @(negedge clk);
        chk("redir_pre", 64'(bus.redirect_valid_o_jtq), 64'd0);
        chk("redir_stall", 64'(bus.stall_o_jtq), 64'd0);
        tick();
        clr_req();
        @(negedge clk);
        chk("redir_valid", 64'(bus.redirect_valid_o_jtq), 64'd1);
        chk("redir_dst", 64'(bus.redirect_dst_o_jtq), 64'h1ABCD);
        chk("redir_no_tok", 64'(bus.tok_valid_o_jtq), 64'd0);
        tick();
        @(negedge clk);
        chk("redir_pulse_end", 64'(bus.redirect_valid_o_jtq), 64'd0);

        // single token
        tick();
        bus.tok_ready_i_jtq = 1'b1;
        set_req(1'b1, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 17'h00123, 1'b0, 32'hDEADBEEF);
        @(negedge clk);
`ifdef JTQ_BYPASS_EN
        chk("tok_byp_valid", 64'(bus.tok_valid_o_jtq), 64'd1);
        chk("tok_byp_data", 64'(bus.tok_data_o_jtq), 64'hDEADBEEF);
`else
        chk("tok_acc_cycle", 64'(bus.tok_valid_o_jtq), 64'd0);
`endif
        tick();
        clr_req();
        @(negedge clk);
`ifdef JTQ_BYPASS_EN
        chk("tok_byp_consumed", 64'(bus.tok_valid_o_jtq), 64'd0);
`else
        chk("tok_valid", 64'(bus.tok_valid_o_jtq), 64'd1);
        chk("tok_pe", 64'(bus.tok_pe_num_o_jtq), 64'd5);
        chk("tok_lr", 64'(bus.tok_lr_o_jtq), 64'd1);
        chk("tok_dst", 64'(bus.tok_dst_o_jtq), 64'h00123);
`endif
        chk("tok_data", 64'(bus.tok_data_o_jtq), 64'hDEADBEEF);
        tick();
        @(negedge clk);
        chk("tok_popped", 64'(bus.tok_valid_o_jtq), 64'd0);
        chk("tok_hold_data", 64'(bus.tok_data_o_jtq), 64'hDEADBEEF);
        chk("tok_hold_pe", 64'(bus.tok_pe_num_o_jtq), 64'd5);

        // full queue: five requests with the network stalled
        bus.tok_ready_i_jtq = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            set_req(1'b1, 1'b1, 3'(i), 1'b0, 1'b1, 1'b0, 17'(i), 1'b0, 32'(i));
            @(negedge clk);
            chk($sformatf("full_stall_%0d", i), 64'(bus.stall_o_jtq), (i == 5) ? 64'd1 : 64'd0);
            if (i >= 2) begin
                chk($sformatf("full_head_%0d", i), 64'(bus.tok_data_o_jtq), 64'd1);
            end
        end
        tick();
        bus.tok_ready_i_jtq = 1'b1;
        @(negedge clk);
        chk("full_pop_stall", 64'(bus.stall_o_jtq), 64'd1);
        chk("full_out_1", 64'(bus.tok_data_o_jtq), 64'd1);
        chk("full_memw", 64'(bus.tok_memw_o_jtq), 64'd1);
        tick();
        @(negedge clk);
        chk("full_unstall", 64'(bus.stall_o_jtq), 64'd0);
        chk("full_out_2", 64'(bus.tok_data_o_jtq), 64'd2);
        tick();
        clr_req();
        for (int i = 3; i <= 5; i++) begin
            @(negedge clk);
            chk($sformatf("full_valid_%0d", i), 64'(bus.tok_valid_o_jtq), 64'd1);
            chk($sformatf("full_out_%0d", i), 64'(bus.tok_data_o_jtq), 64'(i));
            tick();
        end
        @(negedge clk);
        chk("full_drained", 64'(bus.tok_valid_o_jtq), 64'd0);

        // gate: token A, gate, token B; ack three cycles after busy rises
        tick();
        bus.gate_ack_i_jtq = 1'b1;
        set_req(1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 17'h0000A, 1'b0, 32'hA);
        @(negedge clk);
`ifdef JTQ_BYPASS_EN
        chk("gate_a_byp", 64'(bus.tok_data_o_jtq), 64'hA);
`else
        chk("gate_a_wait", 64'(bus.tok_valid_o_jtq), 64'd0);
`endif
        chk("gate_ack_in_run", 64'(bus.gate_busy_o_jtq), 64'd0);
        tick();
        bus.gate_ack_i_jtq = 1'b0;
        set_req(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 17'd0, 1'b1, 32'hFF);
        @(negedge clk);
`ifdef JTQ_BYPASS_EN
        chk("gate_a_gone", 64'(bus.tok_valid_o_jtq), 64'd0);
`else
        chk("gate_a_valid", 64'(bus.tok_valid_o_jtq), 64'd1);
        chk("gate_a_data", 64'(bus.tok_data_o_jtq), 64'hA);
`endif
        chk("gate_busy_c2", 64'(bus.gate_busy_o_jtq), 64'd0);
        tick();
        set_req(1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 17'h0000B, 1'b0, 32'hB);
        @(negedge clk);
        chk("gate_marker_no_tok", 64'(bus.tok_valid_o_jtq), 64'd0);
        chk("gate_c3_stall", 64'(bus.stall_o_jtq), 64'd0);
        tick();
        clr_req();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("gate_busy_%0d", c), 64'(bus.gate_busy_o_jtq), 64'd1);
            chk($sformatf("gate_stall_%0d", c), 64'(bus.stall_o_jtq), 64'd1);
            chk($sformatf("gate_b_held_%0d", c), 64'(bus.tok_valid_o_jtq), 64'd0);
            tick();
        end
        bus.gate_ack_i_jtq = 1'b1;
        @(negedge clk);
        chk("gate_busy_at_ack", 64'(bus.gate_busy_o_jtq), 64'd1);
        tick();
        bus.gate_ack_i_jtq = 1'b0;
        @(negedge clk);
        chk("gate_busy_fall", 64'(bus.gate_busy_o_jtq), 64'd0);
        chk("gate_b_valid", 64'(bus.tok_valid_o_jtq), 64'd1);
        chk("gate_b_data", 64'(bus.tok_data_o_jtq), 64'hB);
        chk("gate_b_pe", 64'(bus.tok_pe_num_o_jtq), 64'd2);
        chk("gate_after_stall", 64'(bus.stall_o_jtq), 64'd0);
        tick();
        @(negedge clk);
        chk("gate_b_popped", 64'(bus.tok_valid_o_jtq), 64'd0);

        // reset with three queued tokens and a pending redirect
        bus.tok_ready_i_jtq = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            set_req(1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 17'd7, 1'b0, 32'(i * 17));
        end
        tick();
        set_req(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 17'h00055, 1'b0, 32'd0);
        tick();
        clr_req();
        #1;
        chk("rst_pre_redir", 64'(bus.redirect_valid_o_jtq), 64'd1);
        chk("rst_pre_tok", 64'(bus.tok_valid_o_jtq), 64'd1);
        rst = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        tick();
        tick();
        rst = 1'b0;
        bus.tok_ready_i_jtq = 1'b1;
        @(negedge clk);
        chk("rst_empty", 64'(bus.tok_valid_o_jtq), 64'd0);
        tick();
        @(negedge clk);
        chk("rst_empty2", 64'(bus.tok_valid_o_jtq), 64'd0);
        chk("rst_no_stall", 64'(bus.stall_o_jtq), 64'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
